// File: rtl/reg_piso_pkg.sv
// reg_piso_pkg: shared definitions for the reg_piso parallel-in/serial-out block.
//   state_e  : FSM state encoding (ST_IDLE, ST_SHIFT)
//   cnt_w()  : bit-counter width, max(1, clog2(DATA_W))
package reg_piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit-position counter for reg_piso.
// Enabled, synchronously reset up-counter with clear.
// It saturates at DATA_W-1 and never wraps.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0), overrides en_i
//   en_i   : clock enable
//   clr_i  : clear to 0 (takes priority over inc_i)
//   inc_i  : advance by one unless already at terminal count
//   tc_o   : count == DATA_W-1
module piso_bit_counter
    import reg_piso_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = cnt_w(DATA_W)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_piso.sv
// reg_piso: parallel-in / serial-out reader for a stored register word.
// A DATA_W word is accepted over a valid/ready load handshake. It is then
// shifted out one bit per accepted serial transfer, with last_o marking the
// final bit.
// Default order is LSB-first. Define REG_PISO_MSB_FIRST_EN for MSB-first.
// Ports:
//   clk_i, rst_i (sync, active-high, overrides en_i), en_i (clock enable)
//   load_valid_i / load_ready_o / load_data_i : parallel load handshake
//   bit_valid_o / bit_ready_i / bit_o / last_o : serial output handshake
//   busy_o : word in flight
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word held; ready for a load once out of reset
// ST_SHIFT | word held; presenting bit at current position, awaiting ready
module reg_piso
    import reg_piso_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              bit_valid_o,
    input  logic              bit_ready_i,
    output logic              bit_o,
    output logic              last_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ready_q, ready_d;
    logic              cnt_tc;
    logic              load_fire;
    logic              bit_fire;

    // ready_q is held low through reset and rises on the first enabled edge
    // after it. Loads are gated on ready_q, so a word offered during reset
    // waits for that edge.
    assign load_fire = load_valid_i & ready_q & en_i;
    assign bit_fire  = (state_q == ST_SHIFT) & bit_ready_i & en_i;

    piso_bit_counter #(
        .DATA_W(DATA_W)
    ) u_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (en_i),
        .clr_i(load_fire),
        .inc_i(bit_fire),
        .tc_o (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    shreg_d = load_data_i;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_fire) begin
`ifdef REG_PISO_MSB_FIRST_EN
                    shreg_d = shreg_q << 1;
`else
                    shreg_d = shreg_q >> 1;
`endif
                    if (cnt_tc) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= RST_VAL;
            ready_q <= 1'b0;
        end else if (en_i) begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
        end
    end

    assign load_ready_o = ready_q;
    assign bit_valid_o  = (state_q == ST_SHIFT);
    assign busy_o       = (state_q == ST_SHIFT);
    assign last_o       = (state_q == ST_SHIFT) & cnt_tc;
`ifdef REG_PISO_MSB_FIRST_EN
    assign bit_o        = shreg_q[DATA_W-1];
`else
    assign bit_o        = shreg_q[0];
`endif

endmodule

// File: tb/tb_reg_piso.sv
module tb_reg_piso;

    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, lv, br;
    logic [W-1:0] ld;
    logic         lr, bv, bo, lo, busy;

    logic       rst1, en1, lv1, br1;
    logic [0:0] ld1;
    logic       lr1, bv1, bo1, lo1, busy1;

    reg_piso #(.DATA_W(W), .RST_VAL(RV)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .load_valid_i(lv), .load_ready_o(lr), .load_data_i(ld),
        .bit_valid_o(bv), .bit_ready_i(br), .bit_o(bo), .last_o(lo),
        .busy_o(busy)
    );

    reg_piso #(.DATA_W(1), .RST_VAL(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .en_i(en1),
        .load_valid_i(lv1), .load_ready_o(lr1), .load_data_i(ld1),
        .bit_valid_o(bv1), .bit_ready_i(br1), .bit_o(bo1), .last_o(lo1),
        .busy_o(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_busy = 0;
    bit           m_ready = 0;
    int           m_idx = 0;
    logic [W-1:0] m_word = '0;
    bit           m_ibk = 0;     // idle bit known (just reset)
    logic         m_ibit = 1'b0;
    int           n_loads = 0;
    int           n_words = 0;
    bit           cmp_on = 0;
    logic         act_b[$];
    logic         act_l[$];
    logic [W-1:0] rv_v = RV;

    function automatic logic exp_bit();
`ifdef REG_PISO_MSB_FIRST_EN
        return m_word[W-1-m_idx];
`else
        return m_word[m_idx];
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_ready = 0; m_idx = 0; m_ibk = 1;
`ifdef REG_PISO_MSB_FIRST_EN
            m_ibit = rv_v[W-1];
`else
            m_ibit = rv_v[0];
`endif
            cmp_on = 1;
        end else if (en) begin
            if (m_busy) begin
                if (br) begin
                    act_b.push_back(bo);
                    act_l.push_back(lo);
                    if (m_idx == W-1) begin
                        m_busy = 0;
                        n_words++;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_ready && lv) begin
                m_busy = 1; m_word = ld; m_idx = 0; m_ibk = 0;
                n_loads++;
            end
            m_ready = !m_busy;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("bit_valid", bv, m_busy);
            chk("load_ready", lr, m_ready);
            chk("busy", busy, m_busy);
            chk("last", lo, (m_busy && m_idx == W-1));
            if (m_busy) chk("bit", bo, exp_bit());
            else if (m_ibk) chk("bit_after_rst", bo, m_ibit);
        end
    end

    // ---------------- bit_ready driver ----------------
    int brmode = 0;
    int pat = 0;
    initial begin
        br = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (brmode)
                1: begin br = (pat % 3 == 0); pat++; end
                2: br = 1'($urandom_range(0, 1));
                default: br = 1'b1;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic start_load(input logic [W-1:0] w);
        int l0;
        l0 = n_loads;
        lv = 1'b1; ld = w;
        for (int i = 0; i < 100 && n_loads == l0; i++) @(negedge clk);
        chk("load_accept_timeout", (n_loads != l0), 1);
        #1 lv = 1'b0; ld = W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && m_busy; i++) @(negedge clk);
        chk("word_done_timeout", m_busy, 0);
    endtask

    task automatic wait_bits(input int target);
        for (int i = 0; i < 100 && act_b.size() < target; i++) @(negedge clk);
        chk("bit_count_timeout", (act_b.size() >= target), 1);
    endtask

    task automatic check_seq(input string nm, input int base, input logic [W-1:0] exp);
        logic [W-1:0] bv_v, lv_v;
        bv_v = '0; lv_v = '0;
        chk({nm, "_count"}, act_b.size() - base, W);
        for (int i = 0; i < W; i++) begin
            if (base + i < act_b.size()) begin
                bv_v[i] = act_b[base+i];
                lv_v[i] = act_l[base+i];
            end
        end
        chk({nm, "_bits"}, bv_v, exp);
        chk({nm, "_last"}, lv_v, 8'h80);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int base, w0;
        logic hold_b, hold_l;
        rst = 1'b1; en = 1'b1; lv = 1'b0; ld = '0;
        rst1 = 1'b1; en1 = 1'b1; lv1 = 1'b0; ld1 = '0; br1 = 1'b0;

        // reset held for 3 edges
        repeat (3) begin
            @(negedge clk);
            chk("rst_bit_valid", bv, 0);
            chk("rst_last", lo, 0);
            chk("rst_bit", bo, 1);
            chk("rst_load_ready", lr, 0);
            chk("rst_busy", busy, 0);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", lr, 1);

        // basic word, ready always high
        brmode = 0;
        base = act_b.size();
        start_load(8'hB4);
        wait_done();
        chk("b4_ready_back", lr, 1);
`ifdef REG_PISO_MSB_FIRST_EN
        check_seq("b4", base, 8'h2D);
`else
        check_seq("b4", base, 8'hB4);
`endif

        // backpressure 1,0,0,...
        brmode = 1; pat = 0;
        base = act_b.size();
        start_load(8'h81);
        wait_done();
        check_seq("bp81", base, 8'h81);

        // enable freeze after 3 bits
        brmode = 0;
        base = act_b.size();
        start_load(8'hF0);
        wait_bits(base + 3);
        #1 en = 1'b0;
        hold_b = bo; hold_l = lo;
        repeat (4) begin
            @(negedge clk);
            chk("freeze_count", act_b.size() - base, 3);
            chk("freeze_bit", bo, hold_b);
            chk("freeze_last", lo, hold_l);
            chk("freeze_valid", bv, 1);
        end
        #1 en = 1'b1;
        wait_done();
`ifdef REG_PISO_MSB_FIRST_EN
        check_seq("f0", base, 8'h0F);
`else
        check_seq("f0", base, 8'hF0);
`endif

        // reset mid-word, then a word offered through reset
        base = act_b.size();
        w0 = n_words;
        start_load(8'hFF);
        wait_bits(base + 2);
        #1 rst = 1'b1; lv = 1'b1; ld = 8'h01;
        @(negedge clk);
        #1 rst = 1'b0;
        chk("abort_count", act_b.size() - base, 2);
        chk("abort_last0", act_l[base], 0);
        chk("abort_last1", act_l[base+1], 0);
        chk("abort_no_word", n_words - w0, 0);
        base = act_b.size();
        start_load(8'h01);
        wait_done();
`ifdef REG_PISO_MSB_FIRST_EN
        check_seq("w01", base, 8'h80);
`else
        check_seq("w01", base, 8'h01);
`endif

        // randomized traffic
        brmode = 2;
        w0 = n_words;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            lv  = 1'($urandom_range(0, 1));
            ld  = W'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 149) == 0);
        end
        #1 rst = 1'b0; en = 1'b1; lv = 1'b0; brmode = 0;
        @(negedge clk);
        wait_done();
        chk("random_words_seen", (n_words > w0), 1);

        // DATA_W = 1 instance
        @(negedge clk);
        chk("w1_rst_valid", bv1, 0);
        chk("w1_rst_bit", bo1, 1);
        chk("w1_rst_last", lo1, 0);
        #1 rst1 = 1'b0;
        @(negedge clk);
        chk("w1_ready", lr1, 1);
        #1 lv1 = 1'b1; ld1 = 1'b1;
        @(negedge clk);
        chk("w1_valid", bv1, 1);
        chk("w1_bit", bo1, 1);
        chk("w1_last", lo1, 1);
        chk("w1_busy", busy1, 1);
        chk("w1_not_ready", lr1, 0);
        #1 lv1 = 1'b0; br1 = 1'b1;
        @(negedge clk);
        chk("w1_done_valid", bv1, 0);
        chk("w1_done_ready", lr1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
